// File: rtl/nn_infer_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : nn_infer_sequencer
//  Description : Buffers ADC sample pairs, normalises them and drives the
//                inference core handshake one inference at a time, returning
//                each result on a valid/ready stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module nn_infer_sequencer #(
    parameter int DEPTH   = 4,
    parameter int OFFSET  = 2097151,
    parameter int SHIFT   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        nn_start,
    output logic        nn_in_vld,
    output logic [35:0] nn_in,
    input  logic        nn_ready,
    input  logic        nn_done,
    input  logic [17:0] nn_out,
    output logic [17:0] m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  abort_cnt
);

    localparam int c_ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_TMR_W  = $clog2(TIMEOUT + 1);

    localparam logic [c_ADDR_W-1:0] c_PTR_ONE  = 1;
    localparam logic [c_ADDR_W:0]   c_CNT_ONE  = 1;
    localparam logic [c_ADDR_W:0]   c_CNT_FULL = DEPTH[c_ADDR_W:0];
    localparam logic [c_TMR_W-1:0]  c_TMR_ONE  = 1;
    localparam logic [c_TMR_W-1:0]  c_TMR_LAST = c_TMR_W'(TIMEOUT - 1);
    localparam logic [7:0]          c_CNT_MAX  = 8'hFF;

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_ISSUE = 3'd1;
    localparam logic [2:0] c_S_WAIT  = 3'd2;
    localparam logic [2:0] c_S_ABORT = 3'd3;
    localparam logic [2:0] c_S_HOLD  = 3'd4;

    logic [63:0]         r_mem [DEPTH];
    logic [c_ADDR_W-1:0] r_wr_ptr;
    logic [c_ADDR_W-1:0] r_rd_ptr;
    logic [c_ADDR_W:0]   r_count;
    logic [2:0]          r_state;
    logic [c_TMR_W-1:0]  r_timer;
    logic                r_nn_start;
    logic                r_nn_in_vld;
    logic [35:0]         r_nn_in;
    logic [17:0]         r_m_data;
    logic                r_m_valid;
    logic                r_timeout_err;
    logic [7:0]          r_abort_cnt;

    logic                w_full;
    logic                w_empty;
    logic                w_push;
    logic                w_pop;
    logic [63:0]         w_rd_data;
    logic [35:0]         w_norm;

    // Bias the signed channel, shift the 36-bit word and keep the top 18 bits.
    function automatic logic [17:0] f_norm(input logic [31:0] ch);
        logic [32:0] sum;
        sum = {ch[31], ch} + 33'(OFFSET);
        return 18'(({3'b000, sum} << SHIFT) >> 18);
    endfunction

    assign w_full    = (r_count == c_CNT_FULL);
    assign w_empty   = (r_count == '0);
    assign w_push    = s_valid && !w_full;
    assign w_pop     = (r_state == c_S_IDLE) && !w_empty;
    assign w_rd_data = r_mem[r_rd_ptr];
    assign w_norm    = {f_norm(w_rd_data[63:32]), f_norm(w_rd_data[31:0])};

    assign s_ready     = !w_full;
    assign nn_start    = r_nn_start;
    assign nn_in_vld   = r_nn_in_vld;
    assign nn_in       = r_nn_in;
    assign m_data      = r_m_data;
    assign m_valid     = r_m_valid;
    assign busy        = (r_state != c_S_IDLE) || !w_empty;
    assign timeout_err = r_timeout_err;
    assign abort_cnt   = r_abort_cnt;

    always_ff @(posedge ap_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= s_data;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state       <= c_S_IDLE;
            r_timer       <= '0;
            r_nn_start    <= 1'b0;
            r_nn_in_vld   <= 1'b0;
            r_nn_in       <= '0;
            r_m_data      <= '0;
            r_m_valid     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_abort_cnt   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (w_pop) begin
                        r_nn_in     <= w_norm;
                        r_nn_start  <= 1'b1;
                        r_nn_in_vld <= 1'b1;
                        r_state     <= c_S_ISSUE;
                    end
                end
                c_S_ISSUE: begin
                    if (nn_ready) begin
                        r_nn_start  <= 1'b0;
                        r_nn_in_vld <= 1'b0;
                        r_timer     <= '0;
                        if (nn_done) begin
                            r_m_data  <= nn_out;
                            r_m_valid <= 1'b1;
                            r_state   <= c_S_HOLD;
                        end else begin
                            r_state <= c_S_WAIT;
                        end
                    end
                end
                c_S_WAIT: begin
                    // A result arriving on the last permitted cycle still wins.
                    if (nn_done) begin
                        r_m_data  <= nn_out;
                        r_m_valid <= 1'b1;
                        r_state   <= c_S_HOLD;
                    end else if (r_timer == c_TMR_LAST) begin
                        r_state <= c_S_ABORT;
                    end else begin
                        r_timer <= r_timer + c_TMR_ONE;
                    end
                end
                c_S_ABORT: begin
                    r_timeout_err <= 1'b1;
                    if (r_abort_cnt != c_CNT_MAX) begin
                        r_abort_cnt <= r_abort_cnt + 8'd1;
                    end
                    r_state <= c_S_IDLE;
                end
                c_S_HOLD: begin
                    if (m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= c_S_IDLE;
                    end
                end
                default: begin
                    r_nn_start  <= 1'b0;
                    r_nn_in_vld <= 1'b0;
                    r_m_valid   <= 1'b0;
                    r_state     <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
